// File: rtl/pika_mem_pkg.sv
// Shared constants for the data-memory responder: MMIO map, status bits, FSM states.
// No logic of its own; pack_status builds the CONSOLE_STATUS read word.
package pika_mem_pkg;

    localparam logic [15:0] CONSOLE_DATA   = 16'h0000;
    localparam logic [15:0] CONSOLE_STATUS = 16'h0001;
    localparam logic [15:0] CYCLE          = 16'h0002;

    localparam int EMPTY = 0;
    localparam int FULL  = 1;
    localparam int OVF   = 2;
    localparam int FAULT = 3;

    localparam logic [31:0] FAULT_PATTERN = 32'hDEADBEEF;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } resp_state_t;

    function automatic logic [31:0] pack_status(input logic empty_f, input logic full_f,
                                                input logic ovf_f, input logic fault_f);
        logic [31:0] s;
        s        = '0;
        s[EMPTY] = empty_f;
        s[FULL]  = full_f;
        s[OVF]   = ovf_f;
        s[FAULT] = fault_f;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered storage, head shown combinationally; push-to-valid is one cycle.
// A push while full is accepted only when a pop happens in the same cycle, otherwise dropped.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_dat,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic [DEPTH_LOG2:0]   cnt_d;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign head_dat = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is reset so the head byte reads 0 before anything is pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM cleared after reset, plus MMIO console FIFO and cycle counter.
// Reads are zero-latency; writes land on clk. Optional DMEM_BOUNDS_CHECK_EN traps out-of-range RAM accesses.
import pika_mem_pkg::*;

module data_mem_responder #(
    parameter int          DEPTH_LOG2      = 10,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] MMIO_TAG        = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_write_en,
    input  logic [31:0] dmem_val_out,
    output logic [31:0] dmem_val_in,
    output logic        mem_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           ram [RAM_WORDS];
    resp_state_t           state_q;
    logic [DEPTH_LOG2-1:0] clr_idx_q;
    logic                  mem_ready_q;
    logic [31:0]           cycle_q;
    logic                  ovf_q;
    logic                  fault_q;

    logic                  is_mmio;
    logic [15:0]           mmio_ofs;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  oob;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_cnt;
    logic                  stat_wr;
    logic                  cycle_wr;
    logic                  ram_we;
    logic                  ovf_set;
    logic [31:0]           rdata;

    assign is_mmio  = (dmem_addr[31:16] == MMIO_TAG);
    assign mmio_ofs = dmem_addr[15:0];
    assign ram_idx  = dmem_addr[DEPTH_LOG2-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = !is_mmio && (dmem_addr[31:DEPTH_LOG2] != '0);
`else
    assign oob = 1'b0;
`endif

    assign fifo_push = dmem_write_en && is_mmio && (mmio_ofs == CONSOLE_DATA);
    assign stat_wr   = dmem_write_en && is_mmio && (mmio_ofs == CONSOLE_STATUS);
    assign cycle_wr  = dmem_write_en && is_mmio && (mmio_ofs == CYCLE);
    assign ram_we    = dmem_write_en && !is_mmio && !oob && (state_q == READY);
    assign fifo_pop  = tx_valid && tx_ready;
    assign ovf_set   = fifo_push && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_console_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (dmem_val_out[7:0]),
        .pop      (fifo_pop),
        .head_dat (tx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign tx_valid  = (fifo_cnt != '0);
    assign mem_ready = mem_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            mem_ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == '1) begin
                        state_q     <= READY;
                        mem_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= READY;
                end
            endcase
        end
    end

    // The clear sweep owns the write port; core writes only reach RAM once READY.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            ram[clr_idx_q] <= '0;
        end else if (ram_we) begin
            ram[ram_idx] <= dmem_val_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            ovf_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            cycle_q <= cycle_wr ? dmem_val_out : cycle_q + 32'd1;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (stat_wr) begin
                ovf_q <= 1'b0;
            end
            if (oob) begin
                fault_q <= 1'b1;
            end else if (stat_wr) begin
                fault_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (is_mmio) begin
            case (mmio_ofs)
                CONSOLE_STATUS: rdata = pack_status(fifo_empty, fifo_full, ovf_q, fault_q);
                CYCLE:          rdata = cycle_q;
                default:        rdata = '0;
            endcase
        end else if (oob) begin
            rdata = FAULT_PATTERN;
        end else if (state_q == READY) begin
            rdata = ram[ram_idx];
        end
    end

    assign dmem_val_in = rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: reference model of RAM, console queue and counter, checked every cycle.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dmem_addr;
    logic        dmem_write_en;
    logic [31:0] dmem_val_out;
    logic [31:0] dmem_val_in;
    logic        mem_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .dmem_addr     (dmem_addr),
        .dmem_write_en (dmem_write_en),
        .dmem_val_out  (dmem_val_out),
        .dmem_val_in   (dmem_val_in),
        .mem_ready     (mem_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_ram [1024];
    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic        m_fault;
    logic [31:0] m_cycle;
    int          m_clr;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_vld;
        logic [7:0]  exp_dat;
    } vec_t;

    vec_t vecs [0:18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bit m_oob(input logic [31:0] a);
        bit en;
`ifdef DMEM_BOUNDS_CHECK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (a[31:16] != 16'hFFFF) && (a[31:10] != 22'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:16] == 16'hFFFF) begin
            if (a[15:0] == 16'd1)
                return {28'd0, m_fault, m_ovf, m_q.size() == 16, m_q.size() == 0};
            if (a[15:0] == 16'd2) return m_cycle;
            return 32'd0;
        end
        if (m_oob(a)) return 32'hDEADBEEF;
        if (m_clr < 1024) return 32'd0;
        return m_ram[a[9:0]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_ram[i] = 32'd0;
        m_q.delete();
        m_ovf   = 1'b0;
        m_fault = 1'b0;
        m_cycle = 32'd0;
        m_clr   = 0;
    endtask

    // Drive one cycle of inputs, compare against the model, advance the model, cross the edge.
    task automatic step(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic rdy);
        int  sz;
        bit  mmio, push, pop, ovf_set, stat_wr;
        dmem_addr     = a;
        dmem_write_en = we;
        dmem_val_out  = wd;
        tx_ready      = rdy;
        #1;
        check("rdata", dmem_val_in, m_read(a));
        check("mem_ready", {31'd0, mem_ready}, {31'd0, m_clr >= 1024});
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
        sz      = m_q.size();
        mmio    = (a[31:16] == 16'hFFFF);
        push    = we && mmio && (a[15:0] == 16'd0);
        stat_wr = we && mmio && (a[15:0] == 16'd1);
        pop     = rdy && (sz > 0);
        ovf_set = push && (sz == 16) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !ovf_set) m_q.push_back(wd[7:0]);
        if (ovf_set) m_ovf = 1'b1;
        else if (stat_wr) m_ovf = 1'b0;
        if (m_oob(a)) m_fault = 1'b1;
        else if (stat_wr) m_fault = 1'b0;
        if (we && mmio && (a[15:0] == 16'd2)) m_cycle = wd;
        else m_cycle = m_cycle + 32'd1;
        if (we && !mmio && !m_oob(a) && (m_clr >= 1024)) m_ram[a[9:0]] = wd;
        if (m_clr < 1024) m_clr++;
        @(negedge clk);
    endtask

    task automatic xchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        dmem_addr     = a;
        dmem_write_en = 1'b0;
        tx_ready      = 1'b0;
        #1;
        check(nm, dmem_val_in, exp);
    endtask

    task automatic do_reset(input int n);
        reset         = 1'b1;
        dmem_addr     = 32'd0;
        dmem_write_en = 1'b0;
        dmem_val_out  = 32'd0;
        tx_ready      = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic clear_phase(input string nm);
        int zeros = 0;
        for (int i = 0; i < 1100; i++) begin
            if (mem_ready === 1'b0) zeros++;
            if (i == 100) step(32'd5, 1'b1, 32'h55, 1'b0);
            else          step(32'd5, 1'b0, 32'd0, 1'b0);
        end
        check(nm, zeros, 32'd1024);
    endtask

    initial begin
        logic [31:0] a;
        vecs[0]  = '{32'd7,         1'b1, 32'h12345678, 1'b0, 1'b1, 32'd0,         1'b0, 8'h00};
        vecs[1]  = '{32'd7,         1'b0, 32'd0,        1'b0, 1'b1, 32'h12345678,  1'b0, 8'h00};
        vecs[2]  = '{32'hFFFF0000,  1'b1, 32'h41,       1'b0, 1'b1, 32'd0,         1'b0, 8'h00};
        vecs[3]  = '{32'hFFFF0000,  1'b1, 32'h42,       1'b0, 1'b1, 32'd0,         1'b1, 8'h41};
        vecs[4]  = '{32'hFFFF0001,  1'b0, 32'd0,        1'b0, 1'b1, 32'd0,         1'b1, 8'h41};
        vecs[5]  = '{32'hFFFF0001,  1'b0, 32'd0,        1'b1, 1'b1, 32'd0,         1'b1, 8'h41};
        vecs[6]  = '{32'hFFFF0001,  1'b0, 32'd0,        1'b1, 1'b1, 32'd0,         1'b1, 8'h42};
        vecs[7]  = '{32'hFFFF0001,  1'b0, 32'd0,        1'b0, 1'b1, 32'd1,         1'b0, 8'h00};
        vecs[8]  = '{32'hFFFF0002,  1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 32'd0,         1'b0, 8'h00};
        vecs[9]  = '{32'hFFFF0002,  1'b0, 32'd0,        1'b0, 1'b1, 32'hFFFFFFFE,  1'b0, 8'h00};
        vecs[10] = '{32'hFFFF0002,  1'b0, 32'd0,        1'b0, 1'b1, 32'hFFFFFFFF,  1'b0, 8'h00};
        vecs[11] = '{32'hFFFF0002,  1'b0, 32'd0,        1'b0, 1'b1, 32'd0,         1'b0, 8'h00};
`ifdef DMEM_BOUNDS_CHECK_EN
        vecs[12] = '{32'h400,       1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 8'h00};
        vecs[13] = '{32'd0,         1'b0, 32'd0,        1'b0, 1'b1, 32'd0,         1'b0, 8'h00};
        vecs[14] = '{32'hFFFF0001,  1'b0, 32'd0,        1'b0, 1'b1, 32'd9,         1'b0, 8'h00};
        vecs[15] = '{32'hFFFF0001,  1'b1, 32'd0,        1'b0, 1'b1, 32'd9,         1'b0, 8'h00};
`else
        vecs[12] = '{32'h400,       1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 32'd0,         1'b0, 8'h00};
        vecs[13] = '{32'd0,         1'b0, 32'd0,        1'b0, 1'b1, 32'hCAFEF00D,  1'b0, 8'h00};
        vecs[14] = '{32'hFFFF0001,  1'b0, 32'd0,        1'b0, 1'b1, 32'd1,         1'b0, 8'h00};
        vecs[15] = '{32'hFFFF0001,  1'b1, 32'd0,        1'b0, 1'b1, 32'd1,         1'b0, 8'h00};
`endif
        vecs[16] = '{32'hFFFF0001,  1'b0, 32'd0,        1'b0, 1'b1, 32'd1,         1'b0, 8'h00};
        vecs[17] = '{32'hFFFF0003,  1'b1, 32'hFF,       1'b0, 1'b1, 32'd0,         1'b0, 8'h00};
        vecs[18] = '{32'hFFFF0003,  1'b0, 32'd0,        1'b0, 1'b1, 32'd0,         1'b0, 8'h00};

        model_reset();
        do_reset(3);
        #1;
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_tx_valid",  {31'd0, tx_valid},  32'd0);
        check("rst_tx_data",   {24'd0, tx_data},   32'd0);
        check("rst_rdata",     dmem_val_in,        32'd0);
        xchk("rst_cycle", 32'hFFFF0002, 32'd0);
        xchk("rst_status", 32'hFFFF0001, 32'd1);

        clear_phase("clear_len");

        for (int i = 0; i < 19; i++) begin
            dmem_addr     = vecs[i].addr;
            dmem_write_en = vecs[i].we;
            dmem_val_out  = vecs[i].wd;
            tx_ready      = vecs[i].rdy;
            #1;
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), dmem_val_in, vecs[i].exp_rd);
            check($sformatf("vec%0d_vld", i), {31'd0, tx_valid}, {31'd0, vecs[i].exp_vld});
            if (vecs[i].exp_vld) check($sformatf("vec%0d_dat", i), {24'd0, tx_data}, {24'd0, vecs[i].exp_dat});
            step(vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].rdy);
        end

        for (int i = 0; i < 17; i++) step(32'hFFFF0000, 1'b1, 32'h60 + i, 1'b0);
        xchk("ovf_status", 32'hFFFF0001, 32'h6);
        step(32'hFFFF0001, 1'b1, 32'd0, 1'b0);
        xchk("ovf_cleared", 32'hFFFF0001, 32'h2);
        step(32'hFFFF0000, 1'b1, 32'h99, 1'b1);
        xchk("full_push_pop", 32'hFFFF0001, 32'h2);
        repeat (20) step(32'hFFFF0001, 1'b0, 32'd0, 1'b1);
        xchk("drained", 32'hFFFF0001, 32'h1);

        for (int i = 0; i < 3000; i++) begin
            int r, o;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                a = 32'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 10);
            end else begin
                o = $urandom_range(0, 7);
                a = 32'hFFFF0000 | ((o < 4) ? 32'd0 : 32'(o - 3));
            end
            step(a, 1'($urandom_range(0, 1)), $urandom,
                 (i < 1500) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1));
        end

        do_reset(2);
        repeat (300) step(32'd0, 1'b0, 32'd0, 1'b0);
        do_reset(1);
        clear_phase("restart_len");
        xchk("ram_cleared", 32'd7, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
